// File: rtl/mps_op_on_seq.sv
// MPS power-up sequencer: discharge, slow-charge and main contactor phases.
// Publishes a 4-bit state code that the system FSM decodes downstream.
module mps_op_on_seq #(
  parameter int                ADC_W      = 16,
  parameter int unsigned       T_DISCHG   = 100000,
  parameter int unsigned       T_SLOW_MAX = 5000000,
  parameter int unsigned       T_MAIN     = 100000,
  parameter int unsigned       T_SLOW_OFF = 100000,
  parameter logic [ADC_W-1:0]  DC_MIN     = ADC_W'(30000),
  parameter int unsigned       T_HOLD     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_op_on_flag,
  input  logic             i_intl_flag,
  input  logic [ADC_W-1:0] i_dc_link,
  output logic [3:0]       o_op_on_fsm,
  output logic             o_busy,
  output logic [1:0]       o_fail_code
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] DIS_OPEN  = 4'd1;
  localparam logic [3:0] DIS_WAIT  = 4'd2;
  localparam logic [3:0] SLOW_ON   = 4'd5;
  localparam logic [3:0] SLOW_WAIT = 4'd6;
  localparam logic [3:0] MAIN_ON   = 4'd9;
  localparam logic [3:0] MAIN_WAIT = 4'd10;
  localparam logic [3:0] SLOW_OFF  = 4'd11;
  localparam logic [3:0] SOFF_WAIT = 4'd12;
  localparam logic [3:0] CHECK     = 4'd13;
  localparam logic [3:0] DONE      = 4'd14;
  localparam logic [3:0] FAIL      = 4'd15;

  localparam logic [31:0] END_DIS  = 32'(T_DISCHG - 1);
  localparam logic [31:0] END_SLOW = 32'(T_SLOW_MAX - 1);
  localparam logic [31:0] END_MAIN = 32'(T_MAIN - 1);
  localparam logic [31:0] END_SOFF = 32'(T_SLOW_OFF - 1);
  localparam logic [31:0] END_HOLD = 32'(T_HOLD - 1);

  logic [3:0]  state;
  logic [3:0]  nxt;
  logic [1:0]  fail;
  logic [1:0]  fail_nxt;
  logic [31:0] cnt;
  logic        dc_ok;

  assign dc_ok = (i_dc_link >= DC_MIN);

  // Dwell counter restarts whenever the state code changes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      fail  <= 2'd0;
      cnt   <= 32'd0;
    end else begin
      state <= nxt;
      fail  <= fail_nxt;
      cnt   <= (nxt != state) ? 32'd0 : cnt + 32'd1;
    end
  end

  always_comb begin
    nxt      = state;
    fail_nxt = fail;
    if (state != IDLE && i_intl_flag) begin
      nxt      = IDLE;
      fail_nxt = 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (i_op_on_flag && !i_intl_flag) begin
            nxt      = DIS_OPEN;
            fail_nxt = 2'd0;
          end
        end
        DIS_OPEN: nxt = DIS_WAIT;
        DIS_WAIT: if (cnt == END_DIS) nxt = SLOW_ON;
        SLOW_ON:  nxt = SLOW_WAIT;
        SLOW_WAIT: begin
          // Threshold wins over a timeout on the same cycle.
          if (dc_ok) begin
            nxt = MAIN_ON;
          end else if (cnt == END_SLOW) begin
            nxt      = FAIL;
            fail_nxt = 2'd1;
          end
        end
        MAIN_ON:   nxt = MAIN_WAIT;
        MAIN_WAIT: if (cnt == END_MAIN) nxt = SLOW_OFF;
        SLOW_OFF:  nxt = SOFF_WAIT;
        SOFF_WAIT: if (cnt == END_SOFF) nxt = CHECK;
        CHECK: begin
          if (dc_ok) begin
            nxt = DONE;
          end else begin
            nxt      = FAIL;
            fail_nxt = 2'd2;
          end
        end
        DONE, FAIL: if (cnt == END_HOLD) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_op_on_fsm = state;
    o_busy      = (state != IDLE);
    o_fail_code = fail;
  end

endmodule

// File: tb/tb_mps_op_on_seq.sv
// Directed bench for mps_op_on_seq with short dwell parameters.
// Walks nominal, timeout, threshold-edge, check-drop, interlock and reset cases.
module tb_mps_op_on_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        op;
  logic        intl;
  logic [15:0] dc;
  logic [3:0]  code;
  logic        busy;
  logic [1:0]  fc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mps_op_on_seq #(
    .ADC_W(16),
    .T_DISCHG(4),
    .T_SLOW_MAX(20),
    .T_MAIN(3),
    .T_SLOW_OFF(3),
    .DC_MIN(16'd1000),
    .T_HOLD(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_op_on_flag(op),
    .i_intl_flag(intl),
    .i_dc_link(dc),
    .o_op_on_fsm(code),
    .o_busy(busy),
    .o_fail_code(fc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Check code/busy/fail for n cycles, advancing one clock after each.
  task automatic run(input logic [3:0] c, input int n, input logic [1:0] f);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("code_in_%0d_cyc%0d", c, i), 32'(code), 32'(c));
      chk($sformatf("busy_in_%0d", c), 32'(busy), 32'(c != 4'd0));
      chk($sformatf("fail_in_%0d", c), 32'(fc), 32'(f));
      tick();
    end
  endtask

  task automatic start();
    op = 1'b1;
    tick();
    op = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    op   = 1'b0;
    intl = 1'b0;
    dc   = 16'd1500;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_code", 32'(code), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fail", 32'(fc), 32'd0);

    // nominal
    start();
    run(4'd1, 1, 2'd0);
    run(4'd2, 4, 2'd0);
    run(4'd5, 1, 2'd0);
    run(4'd6, 1, 2'd0);
    run(4'd9, 1, 2'd0);
    run(4'd10, 3, 2'd0);
    run(4'd11, 1, 2'd0);
    run(4'd12, 3, 2'd0);
    run(4'd13, 1, 2'd0);
    run(4'd14, 1, 2'd0);
    op = 1'b1;
    run(4'd14, 1, 2'd0);
    op = 1'b0;
    run(4'd0, 2, 2'd0);

    // slow-charge timeout
    dc = 16'd500;
    start();
    run(4'd1, 1, 2'd0);
    run(4'd2, 4, 2'd0);
    run(4'd5, 1, 2'd0);
    run(4'd6, 20, 2'd0);
    run(4'd15, 2, 2'd1);
    run(4'd0, 2, 2'd1);

    // threshold reached on the timeout cycle
    start();
    run(4'd1, 1, 2'd0);
    run(4'd2, 4, 2'd0);
    run(4'd5, 1, 2'd0);
    run(4'd6, 19, 2'd0);
    dc = 16'd1200;
    run(4'd6, 1, 2'd0);
    run(4'd9, 1, 2'd0);
    run(4'd10, 3, 2'd0);
    run(4'd11, 1, 2'd0);
    run(4'd12, 3, 2'd0);
    run(4'd13, 1, 2'd0);
    run(4'd14, 2, 2'd0);
    run(4'd0, 1, 2'd0);

    // DC drop before check
    dc = 16'd1500;
    start();
    run(4'd1, 1, 2'd0);
    run(4'd2, 4, 2'd0);
    run(4'd5, 1, 2'd0);
    run(4'd6, 1, 2'd0);
    run(4'd9, 1, 2'd0);
    run(4'd10, 3, 2'd0);
    run(4'd11, 1, 2'd0);
    run(4'd12, 1, 2'd0);
    dc = 16'd800;
    run(4'd12, 2, 2'd0);
    run(4'd13, 1, 2'd0);
    run(4'd15, 2, 2'd2);
    run(4'd0, 1, 2'd2);

    // interlock during main wait
    dc = 16'd1500;
    start();
    run(4'd1, 1, 2'd0);
    run(4'd2, 4, 2'd0);
    run(4'd5, 1, 2'd0);
    run(4'd6, 1, 2'd0);
    run(4'd9, 1, 2'd0);
    run(4'd10, 1, 2'd0);
    intl = 1'b1;
    run(4'd10, 1, 2'd0);
    intl = 1'b0;
    run(4'd0, 4, 2'd3);

    // interlock in idle blocks a start
    intl = 1'b1;
    op   = 1'b1;
    run(4'd0, 1, 2'd3);
    intl = 1'b0;
    op   = 1'b0;
    run(4'd0, 1, 2'd3);

    // restart, stray flag in code 2, reset in code 6
    start();
    run(4'd1, 1, 2'd0);
    op = 1'b1;
    run(4'd2, 1, 2'd0);
    op = 1'b0;
    run(4'd2, 3, 2'd0);
    dc = 16'd500;
    run(4'd5, 1, 2'd0);
    run(4'd6, 3, 2'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(4'd0, 2, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
